fft_r2_sched: RTL and testbench
===============================

# fft_r2_sched

Sequencer for an in-place radix-2 DIT FFT built around one pipelined `butterfly_cordic`. It walks all `N_LOG2` stages. For each butterfly it issues one read-address pair and one twiddle angle per cycle, and it regenerates the matching write-address pair once the memory plus butterfly latency has elapsed. Between stages it drains the pipeline so no stage reads data its predecessor has not yet written. Input data is loaded into the sample memory in bit-reversed order before `start_i`; the result is left in natural order.

## Interface
- `N_LOG2`, 4, log2 of FFT length N; legal range 1..FRAC_BITS+1
- `FRAC_BITS`, 15, butterfly fraction bits; angle width is ANGLE_BITS = FRAC_BITS+1
- `RD_LAT`, 1, sample-memory read latency in cycles
- `BF_LAT`, 8, `butterfly_cordic` input-to-output latency in cycles
- `clk_i  in  1` — single clock, rising edge
- `rst  in  1` — synchronous, active-high reset
- `start_i  in  1` — start request; sampled only in IDLE
- `busy_o  out  1` — high in ISSUE and DRAIN
- `done_o  out  1` — one-cycle pulse when the transform completes
- `rd_en_o  out  1` — read strobe for both memory ports
- `rd_addr_a_o  out  N_LOG2` — read address, butterfly top leg
- `rd_addr_b_o  out  N_LOG2` — read address, butterfly bottom leg
- `twid_o  out  FRAC_BITS+1` — angle code to `twid_i`; 0..2^ANGLE_BITS-1 maps to 0..2π
- `wr_en_o  out  1` — write strobe; write data is butterfly `a_o`/`b_o`
- `wr_addr_a_o  out  N_LOG2` — write address for `a_o`
- `wr_addr_b_o  out  N_LOG2` — write address for `b_o`
- `stage_o  out  ceil(log2(N_LOG2+1))` — current stage index s

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: `start_i`=1 → ISSUE with s=0, k=0.
  - ISSUE: one butterfly per cycle, k = 0..N/2-1. After k=N/2-1 → DRAIN, with the drain counter loaded with LAT = RD_LAT+BF_LAT.
  - DRAIN: counts LAT cycles. Then, if s<N_LOG2-1, s++ and k=0 → ISSUE; otherwise → DONE.
  - DONE: `done_o`=1 for one cycle → IDLE.
- Address generation in ISSUE, with half = 2^s, grp = k>>s, j = k & (half-1):
  - `rd_addr_a_o` = grp·2·half + j
  - `rd_addr_b_o` = `rd_addr_a_o` + half
  - `twid_o` = j << (ANGLE_BITS-1-s), i.e. θ = 2π·j/2^(s+1); the butterfly applies W = e^(-jθ).
- Write side: {rd_en, addr_a, addr_b} pass through a LAT-deep shift register. The register outputs are `wr_en_o`, `wr_addr_a_o`, `wr_addr_b_o`. The twiddle is not delayed.
- All address arithmetic is unsigned and fits N_LOG2 bits without wrap. The twiddle shift stays non-negative within the legal N_LOG2 range.
- `start_i` is ignored outside IDLE.
- `rst` in any state: → IDLE next edge, and the delay line is cleared, so no write strobe follows reset.

## Timing
- Reset values: all outputs 0, `stage_o`=0, state IDLE.
- `start_i` sampled high at edge E0 → first ISSUE cycle is E0..E1, with `rd_en_o`=1 and `busy_o`=1 in that cycle.
- `wr_en_o` for the butterfly read in cycle t is asserted in cycle t+LAT.
- Each stage takes N/2 ISSUE cycles plus LAT DRAIN cycles.
  - The last write of a stage coincides with its last DRAIN cycle.
  - The next stage's first read is one cycle later, so read-after-write is safe.
- `done_o` is high in cycle N_LOG2·(N/2+LAT)+1 after E0, with `busy_o`=0 in that cycle. Defaults: 4·(8+9)+1 = 69.
- `rd_en_o` is 0 in DRAIN, DONE and IDLE. `wr_en_o` may be high in DRAIN only.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs 0. `start_i` pulsed during reset → stays IDLE.
- Defaults, stage 0 → k=0..7 yields pairs (0,1),(2,3)…(14,15) with `twid_o`=0. `wr_en_o` first rises 9 cycles after `rd_en_o`, carrying address pair (0,1).
- Stage 2, k=5 → `rd_addr` (9,13), `twid_o`=8192 (π/4). Stage 3, k=3 → (3,11), `twid_o`=12288 (3π/8). `stage_o` steps 0→1→2→3.
- Start at E0 → `done_o` is a single pulse in cycle 69, with exactly 32 read and 32 write strobes in total. `start_i` held high throughout → no restart until IDLE, then a second run starts.
- Assert `rst` mid-stage 1 with writes in flight → next cycle all strobes 0 and IDLE; a new `start_i` restarts from stage 0, k=0.
- Integration with `butterfly_cordic` and a dual-port memory: bit-reversed impulse x[0]=0.0625 → every bin ≈ 0.0625+j0 within 4 LSB. x[n]=0.0625·cos(2πn/16) → bins 1 and 15 ≈ 0.5, others ≈ 0.

Source files
------------

// File: rtl/fft_r2_sched.sv
// fft_r2_sched: in-place radix-2 DIT FFT sequencer issuing butterfly reads/twiddles and delayed writes
module fft_r2_sched #(
    parameter int N_LOG2    = 4,
    parameter int FRAC_BITS = 15,
    parameter int RD_LAT    = 1,
    parameter int BF_LAT    = 8
) (
    input  logic                             clk_i,
    input  logic                             rst,
    input  logic                             start_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             rd_en_o,
    output logic [N_LOG2-1:0]                rd_addr_a_o,
    output logic [N_LOG2-1:0]                rd_addr_b_o,
    output logic [FRAC_BITS:0]               twid_o,
    output logic                             wr_en_o,
    output logic [N_LOG2-1:0]                wr_addr_a_o,
    output logic [N_LOG2-1:0]                wr_addr_b_o,
    output logic [$clog2(N_LOG2+1)-1:0]      stage_o
);
    localparam int LAT = RD_LAT + BF_LAT;
    localparam int AB  = FRAC_BITS + 1;
    localparam int SW  = $clog2(N_LOG2 + 1);
    localparam int CW  = $clog2(LAT + 1);
    localparam logic [N_LOG2-1:0] HK = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0]          state;
    logic [SW-1:0]       s;
    logic [N_LOG2-1:0]   k, half, j, a;
    logic [CW-1:0]       cnt;
    logic [2*N_LOG2:0]   dl [LAT];
    always_comb begin
        half        = N_LOG2'(1) << s;
        j           = k & (half - N_LOG2'(1));
        a           = (((k >> s) << s) << 1) | j;
        rd_en_o     = state == ISSUE;
        rd_addr_a_o = rd_en_o ? a : '0;
        rd_addr_b_o = rd_en_o ? a + half : '0;
        twid_o      = rd_en_o ? AB'(j) << (AB - 1 - int'(s)) : '0;
        busy_o      = state == ISSUE || state == DRAIN;
        done_o      = state == DONE;
        stage_o     = s;
        {wr_en_o, wr_addr_a_o, wr_addr_b_o} = dl[LAT-1];
    end
    // The delay line is cleared on reset so no stale write strobe escapes after it.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            k     <= '0;
            cnt   <= '0;
            for (int i = 0; i < LAT; i++) dl[i] <= '0;
        end else begin
            dl[0] <= {rd_en_o, rd_addr_a_o, rd_addr_b_o};
            for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
            case (state)
                IDLE: if (start_i) begin
                    state <= ISSUE;
                    s     <= '0;
                    k     <= '0;
                end
                ISSUE: if (k == HK) begin
                    state <= DRAIN;
                    cnt   <= CW'(LAT);
                    k     <= '0;
                end else begin
                    k <= k + N_LOG2'(1);
                end
                DRAIN: if (cnt == CW'(1)) begin
                    state <= (s == SW'(N_LOG2 - 1)) ? DONE : ISSUE;
                    s     <= (s == SW'(N_LOG2 - 1)) ? s : s + SW'(1);
                end else begin
                    cnt <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_r2_sched.sv
// tb_fft_r2_sched: directed self-checking bench for the radix-2 FFT sequencer at default parameters
module tb_fft_r2_sched;
    localparam int LAT = 9;
    localparam int HN  = 8;
    logic        clk_i = 0, rst = 1, start_i = 0;
    logic        busy_o, done_o, rd_en_o, wr_en_o;
    logic [3:0]  rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
    logic [15:0] twid_o;
    logic [2:0]  stage_o;
    int vec = 0, err = 0;

    fft_r2_sched dut (
        .clk_i(clk_i), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .rd_en_o(rd_en_o), .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .twid_o(twid_o),
        .wr_en_o(wr_en_o), .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o), .stage_o(stage_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        start_i = 1;
        repeat (3) begin
            tick();
            vec++;
            if ({busy_o, done_o, rd_en_o, wr_en_o, rd_addr_a_o, rd_addr_b_o, twid_o, wr_addr_a_o, wr_addr_b_o, stage_o} !== '0) begin
                err++;
                $display("FAIL reset_outputs got %h want 0", {busy_o, done_o, rd_en_o, wr_en_o, rd_addr_a_o, rd_addr_b_o, twid_o, wr_addr_a_o, wr_addr_b_o, stage_o});
            end
        end
        rst = 0;
        start_i = 0;
        tick();
        vec++;
        if ({busy_o, rd_en_o} !== 2'b00) begin
            err++;
            $display("FAIL reset_stays_idle got busy=%b rd_en=%b want 0 0", busy_o, rd_en_o);
        end
    endtask

    task automatic test_full_run();
        int ea[32], eb[32], et[32], es[32], ec[32], ra[32], rb[32], rt[32];
        int qa[$], qb[$], qc[$];
        int idx, rd_n, wr_n, done_n, done_c, pa, pb, pc;
        idx = 0;
        for (int s = 0; s < 4; s++)
            for (int g = 0; g < HN >> s; g++)
                for (int j = 0; j < (1 << s); j++) begin
                    ea[idx] = g * 2 * (1 << s) + j;
                    eb[idx] = ea[idx] + (1 << s);
                    et[idx] = j * (32768 >> s);
                    es[idx] = s;
                    ec[idx] = s * (HN + LAT) + 1 + idx % HN;
                    idx++;
                end
        rd_n = 0; wr_n = 0; done_n = 0; done_c = -1;
        start_i = 1;
        tick();
        start_i = 0;
        for (int c = 1; c <= 80; c++) begin
            if (rd_en_o) begin
                vec++;
                if (rd_n >= 32) begin
                    err++;
                    $display("FAIL extra_read c=%0d got read %0d want at most 32", c, rd_n + 1);
                end else begin
                    ra[rd_n] = int'(rd_addr_a_o); rb[rd_n] = int'(rd_addr_b_o); rt[rd_n] = int'(twid_o);
                    if (c != ec[rd_n] || ra[rd_n] != ea[rd_n] || rb[rd_n] != eb[rd_n] || rt[rd_n] != et[rd_n] || int'(stage_o) != es[rd_n] || !busy_o) begin
                        err++;
                        $display("FAIL read%0d got c=%0d (%0d,%0d) tw=%0d st=%0d want c=%0d (%0d,%0d) tw=%0d st=%0d",
                                 rd_n, c, ra[rd_n], rb[rd_n], rt[rd_n], stage_o, ec[rd_n], ea[rd_n], eb[rd_n], et[rd_n], es[rd_n]);
                    end
                    qa.push_back(ra[rd_n]); qb.push_back(rb[rd_n]); qc.push_back(c);
                end
                rd_n++;
            end
            if (wr_en_o) begin
                wr_n++;
                vec++;
                if (qa.size() == 0) begin
                    err++;
                    $display("FAIL write_unmatched c=%0d got (%0d,%0d) want no write", c, wr_addr_a_o, wr_addr_b_o);
                end else begin
                    pa = qa.pop_front(); pb = qb.pop_front(); pc = qc.pop_front();
                    if (int'(wr_addr_a_o) != pa || int'(wr_addr_b_o) != pb || c != pc + LAT || rd_en_o || !busy_o) begin
                        err++;
                        $display("FAIL write c=%0d got (%0d,%0d) rd=%b busy=%b want c=%0d (%0d,%0d) in drain",
                                 c, wr_addr_a_o, wr_addr_b_o, rd_en_o, busy_o, pc + LAT, pa, pb);
                    end
                end
            end
            if (done_o) begin
                done_n++;
                done_c = c;
                vec++;
                if (busy_o) begin
                    err++;
                    $display("FAIL done_busy c=%0d got busy=1 want 0", c);
                end
            end
            tick();
        end
        vec++;
        if (rd_n != 32 || wr_n != 32) begin
            err++;
            $display("FAIL strobe_counts got rd=%0d wr=%0d want 32 32", rd_n, wr_n);
        end
        vec++;
        if (done_n != 1 || done_c != 69) begin
            err++;
            $display("FAIL done_pulse got n=%0d c=%0d want 1 at 69", done_n, done_c);
        end
        vec++;
        if (ra[21] != 9 || rb[21] != 13 || rt[21] != 8192) begin
            err++;
            $display("FAIL s2k5 got (%0d,%0d) tw=%0d want (9,13) tw=8192", ra[21], rb[21], rt[21]);
        end
        vec++;
        if (ra[27] != 3 || rb[27] != 11 || rt[27] != 12288) begin
            err++;
            $display("FAIL s3k3 got (%0d,%0d) tw=%0d want (3,11) tw=12288", ra[27], rb[27], rt[27]);
        end
        vec++;
        if (ra[11] != 5 || rb[11] != 7 || rt[11] != 16384) begin
            err++;
            $display("FAIL s1k3 got (%0d,%0d) tw=%0d want (5,7) tw=16384", ra[11], rb[11], rt[11]);
        end
    endtask

    task automatic test_back_to_back();
        start_i = 1;
        tick();
        for (int c = 1; c <= 75; c++) begin
            if (c == 18) begin
                vec++;
                if (stage_o !== 3'd1 || !rd_en_o) begin
                    err++;
                    $display("FAIL b2b_no_restart got stage=%0d rd=%b want 1 1", stage_o, rd_en_o);
                end
            end
            if (c == 69) begin
                vec++;
                if (done_o !== 1'b1) begin
                    err++;
                    $display("FAIL b2b_done got %b want 1", done_o);
                end
            end
            if (c == 70) begin
                vec++;
                if (busy_o !== 1'b0 || rd_en_o !== 1'b0 || done_o !== 1'b0) begin
                    err++;
                    $display("FAIL b2b_idle got busy=%b rd=%b done=%b want 0 0 0", busy_o, rd_en_o, done_o);
                end
            end
            if (c == 71) begin
                vec++;
                if (!rd_en_o || !busy_o || rd_addr_a_o !== 4'd0 || rd_addr_b_o !== 4'd1 || stage_o !== 3'd0) begin
                    err++;
                    $display("FAIL b2b_restart got rd=%b (%0d,%0d) st=%0d want 1 (0,1) 0", rd_en_o, rd_addr_a_o, rd_addr_b_o, stage_o);
                end
            end
            tick();
        end
        start_i = 0;
        rst = 1;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_mid_reset();
        start_i = 1;
        tick();
        start_i = 0;
        repeat (21) tick();
        vec++;
        if (stage_o !== 3'd1 || !rd_en_o) begin
            err++;
            $display("FAIL mid_setup got stage=%0d rd=%b want 1 1", stage_o, rd_en_o);
        end
        rst = 1;
        tick();
        rst = 0;
        vec++;
        if ({busy_o, rd_en_o, wr_en_o, done_o, stage_o} !== '0) begin
            err++;
            $display("FAIL mid_reset got busy=%b rd=%b wr=%b done=%b st=%0d want all 0", busy_o, rd_en_o, wr_en_o, done_o, stage_o);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            vec++;
            if (wr_en_o || busy_o) begin
                err++;
                $display("FAIL mid_reset_flush c=%0d got wr=%b busy=%b want 0 0", c, wr_en_o, busy_o);
            end
        end
        start_i = 1;
        tick();
        start_i = 0;
        vec++;
        if (!rd_en_o || rd_addr_a_o !== 4'd0 || rd_addr_b_o !== 4'd1 || twid_o !== 16'd0 || stage_o !== 3'd0) begin
            err++;
            $display("FAIL mid_restart got rd=%b (%0d,%0d) tw=%0d st=%0d want 1 (0,1) 0 0", rd_en_o, rd_addr_a_o, rd_addr_b_o, twid_o, stage_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
